// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-port signal bundle for the memory controller.
// slave is the controller's view; master is the requester/RAM side.
interface mem_ctrl_if #(
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
);
    logic                      readyIn;
    logic                      icacheMiss;
    logic [31:BLOCK_WIDTH]     icacheAddr;
    logic                      icacheDataValid;
    logic [31:BLOCK_WIDTH]     icacheAddrOut;
    logic [BLOCK_SIZE*8-1:0]   icacheDataOut;
    logic                      lsbReq;
    logic                      lsbWrite;
    logic [31:0]               lsbAddr;
    logic [1:0]                lsbSize;
    logic [31:0]               lsbDataIn;
    logic                      lsbDone;
    logic [31:0]               lsbDataOut;
    logic [7:0]                ramDataIn;
    logic [7:0]                ramDataOut;
    logic [31:0]               ramAddr;
    logic                      ramWrite;

    modport slave (
        input  readyIn, icacheMiss, icacheAddr, lsbReq, lsbWrite, lsbAddr,
               lsbSize, lsbDataIn, ramDataIn,
        output icacheDataValid, icacheAddrOut, icacheDataOut, lsbDone,
               lsbDataOut, ramDataOut, ramAddr, ramWrite
    );

    modport master (
        output readyIn, icacheMiss, icacheAddr, lsbReq, lsbWrite, lsbAddr,
               lsbSize, lsbDataIn, ramDataIn,
        input  icacheDataValid, icacheAddrOut, icacheDataOut, lsbDone,
               lsbDataOut, ramDataOut, ramAddr, ramWrite
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter: 16-byte ICache refills (18 cycles) and 1/2/4-byte LSB loads/stores (N+2 / N+1 cycles).
// LSB wins ties; readyIn low freezes progress, with the in-flight read byte parked so no data is lost.
module mem_ctrl #(
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input logic       clkIn,
    input logic       resetIn,
    mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, IFETCH, LOAD, STORE, DONE} state_t;

    state_t                  state, next_state;
    logic [4:0]              cnt, cnt_nxt, nbytes, nbytes_nxt, cnt_inc;
    logic [31:0]             base, base_nxt, store_data, store_nxt;
    logic [BLOCK_WIDTH-1:0]  idx;
    logic                    held;
    logic [7:0]              held_byte, rd_byte;

    logic [31:0]             addr_nxt, load_nxt;
    logic [7:0]              wdat_nxt;
    logic                    write_nxt, line_vld_nxt, lsb_done_nxt;
    logic [BLOCK_SIZE*8-1:0] line_nxt;
    logic [31:BLOCK_WIDTH]   line_addr_nxt;

    // cnt is the index of the byte currently on ramAddr; reads capture byte cnt-1.
    assign cnt_inc = cnt + 5'd1;
    assign idx     = BLOCK_WIDTH'(cnt - 5'd1);
    assign rd_byte = held ? held_byte : bus.ramDataIn;

    always_comb begin
        next_state    = state;
        cnt_nxt       = cnt;
        nbytes_nxt    = nbytes;
        base_nxt      = base;
        store_nxt     = store_data;
        addr_nxt      = bus.ramAddr;
        wdat_nxt      = bus.ramDataOut;
        write_nxt     = 1'b0;
        line_nxt      = bus.icacheDataOut;
        line_addr_nxt = bus.icacheAddrOut;
        load_nxt      = bus.lsbDataOut;
        line_vld_nxt  = 1'b0;
        lsb_done_nxt  = 1'b0;
        if (bus.readyIn) begin
            unique case (state)
                IDLE: begin
                    cnt_nxt = 5'd0;
                    if (bus.lsbReq) begin
                        base_nxt   = bus.lsbAddr;
                        store_nxt  = bus.lsbDataIn;
                        addr_nxt   = bus.lsbAddr;
                        unique case (bus.lsbSize)
                            2'd0:    nbytes_nxt = 5'd1;
                            2'd1:    nbytes_nxt = 5'd2;
                            default: nbytes_nxt = 5'd4;
                        endcase
                        if (bus.lsbWrite) begin
                            next_state = STORE;
                            write_nxt  = 1'b1;
                            wdat_nxt   = bus.lsbDataIn[7:0];
                        end else begin
                            next_state = LOAD;
                            load_nxt   = '0;
                        end
                    end else if (bus.icacheMiss) begin
                        next_state    = IFETCH;
                        base_nxt      = {bus.icacheAddr, {BLOCK_WIDTH{1'b0}}};
                        addr_nxt      = {bus.icacheAddr, {BLOCK_WIDTH{1'b0}}};
                        nbytes_nxt    = 5'(BLOCK_SIZE);
                        line_nxt      = '0;
                        line_addr_nxt = bus.icacheAddr;
                    end
                end
                IFETCH, LOAD: begin
                    if (cnt != 5'd0) begin
                        if (state == IFETCH) line_nxt[{idx, 3'b000} +: 8] = rd_byte;
                        else                 load_nxt[{idx[1:0], 3'b000} +: 8] = rd_byte;
                    end
                    if (cnt == nbytes) begin
                        next_state   = DONE;
                        line_vld_nxt = (state == IFETCH);
                        lsb_done_nxt = (state == LOAD);
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc != nbytes) addr_nxt = base + {27'd0, cnt_inc};
                    end
                end
                STORE: begin
                    if (cnt_inc == nbytes) begin
                        next_state   = DONE;
                        lsb_done_nxt = 1'b1;
                    end else begin
                        cnt_nxt   = cnt_inc;
                        addr_nxt  = base + {27'd0, cnt_inc};
                        wdat_nxt  = store_data[{cnt_inc[1:0], 3'b000} +: 8];
                        write_nxt = 1'b1;
                    end
                end
                DONE: begin
                    next_state = IDLE;
                    cnt_nxt    = 5'd0;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state               <= IDLE;
            cnt                 <= '0;
            nbytes              <= '0;
            base                <= '0;
            store_data          <= '0;
            held                <= 1'b0;
            held_byte           <= '0;
            bus.ramAddr         <= '0;
            bus.ramDataOut      <= '0;
            bus.ramWrite        <= 1'b0;
            bus.icacheDataValid <= 1'b0;
            bus.icacheAddrOut   <= '0;
            bus.icacheDataOut   <= '0;
            bus.lsbDone         <= 1'b0;
            bus.lsbDataOut      <= '0;
        end else begin
            state               <= next_state;
            cnt                 <= cnt_nxt;
            nbytes              <= nbytes_nxt;
            base                <= base_nxt;
            store_data          <= store_nxt;
            bus.ramAddr         <= addr_nxt;
            bus.ramDataOut      <= wdat_nxt;
            bus.ramWrite        <= write_nxt;
            bus.icacheDataValid <= line_vld_nxt;
            bus.icacheAddrOut   <= line_addr_nxt;
            bus.icacheDataOut   <= line_nxt;
            bus.lsbDone         <= lsb_done_nxt;
            bus.lsbDataOut      <= load_nxt;
            // The byte arriving on the first frozen cycle is parked and consumed on resume.
            if (!bus.readyIn) begin
                if (!held) held_byte <= bus.ramDataIn;
                held <= 1'b1;
            end else begin
                held <= 1'b0;
            end
        end
    end
endmodule
